// File: rtl/ycbcr_pkg.sv
// Shared constants and state encoding for the YCbCr block sequencer.
package ycbcr_pkg;

  localparam int unsigned BLOCK_PIXELS_DEF = 64;
  localparam int unsigned ADDR_W           = $clog2(BLOCK_PIXELS_DEF);
  localparam int unsigned BLK_CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    DRAIN     = 2'd2,
    WAIT_BANK = 2'd3
  } state_t;

endpackage

// File: rtl/ycbcr_tag_pipe.sv
// Delay line carrying {valid, addr} alongside the converter so each result
// lands at the raster address of the pixel that produced it.
module ycbcr_tag_pipe #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              tag_valid,
  output logic [ADDR_W-1:0] tag_addr,
  output logic              empty,
  output logic              final_tag
);

  // Stages ahead of the output stage; all-zero when DEPTH is 1.
  localparam logic [DEPTH-1:0] UPSTREAM_MASK = {DEPTH{1'b1}} >> 1;

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

  // Shift register; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q[0] <= push;
      addr_q[0]  <= push_addr;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign tag_valid = valid_q[DEPTH-1];
  assign tag_addr  = addr_q[DEPTH-1];
  assign empty     = ~|valid_q;
  // Only the output stage holds a tag: this cycle's write is the last one.
  assign final_tag = valid_q[DEPTH-1] & ~|(valid_q & UPSTREAM_MASK);

endmodule

// File: rtl/ycbcr_block_sequencer.sv
// Feeds RGB pixels to the external converter, writes results into a
// ping-pong block buffer and hands completed banks to the DCT stage.
module ycbcr_block_sequencer
  import ycbcr_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH        = 8,
  parameter int unsigned FIXED_POINT_LENGTH = 32,
  parameter int unsigned BLOCK_PIXELS       = BLOCK_PIXELS_DEF,
  parameter int unsigned CONV_LATENCY       = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [BLK_CNT_W-1:0]             cfg_num_blocks,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [INPUT_WIDTH-1:0]           pix_r,
  input  logic [INPUT_WIDTH-1:0]           pix_g,
  input  logic [INPUT_WIDTH-1:0]           pix_b,
  output logic [INPUT_WIDTH-1:0]           conv_R,
  output logic [INPUT_WIDTH-1:0]           conv_G,
  output logic [INPUT_WIDTH-1:0]           conv_B,
  input  logic [FIXED_POINT_LENGTH-1:0]    conv_Y,
  input  logic [FIXED_POINT_LENGTH-1:0]    conv_Cb,
  input  logic [FIXED_POINT_LENGTH-1:0]    conv_Cr,
  output logic                             wr_en,
  output logic                             wr_bank,
  output logic [$clog2(BLOCK_PIXELS)-1:0]  wr_addr,
  output logic [FIXED_POINT_LENGTH-1:0]    wr_y,
  output logic [FIXED_POINT_LENGTH-1:0]    wr_cb,
  output logic [FIXED_POINT_LENGTH-1:0]    wr_cr,
  output logic                             blk_done,
  output logic                             blk_bank,
  input  logic                             bank_release,
  input  logic                             bank_release_id,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int unsigned      AW       = $clog2(BLOCK_PIXELS);
  localparam logic [AW-1:0]    LAST_PIX = AW'(BLOCK_PIXELS - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        pix_cnt, pix_cnt_nxt;
  logic [BLK_CNT_W-1:0] blk_cnt, blk_cnt_nxt, blk_cnt_inc;
  logic [BLK_CNT_W-1:0] num_blocks, num_blocks_nxt;
  logic                 cur_bank, cur_bank_nxt;
  logic [1:0]           bank_full, bank_full_nxt, rel_mask, set_mask;
  logic                 blk_done_nxt, blk_bank_nxt, frame_done_nxt;
  logic                 accept, pipe_empty, pipe_final, drain_done, last_blk;

  // Converter input and buffer data are straight pass-throughs.
  assign conv_R = pix_r;
  assign conv_G = pix_g;
  assign conv_B = pix_b;
  assign wr_y   = conv_Y;
  assign wr_cb  = conv_Cb;
  assign wr_cr  = conv_Cr;

  assign pix_ready = (state == FILL);
  assign busy      = (state != IDLE);
  assign wr_bank   = cur_bank;
  assign accept    = pix_valid & pix_ready;

  ycbcr_tag_pipe #(
    .DEPTH  (CONV_LATENCY),
    .ADDR_W (AW)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_addr (pix_cnt),
    .tag_valid (wr_en),
    .tag_addr  (wr_addr),
    .empty     (pipe_empty),
    .final_tag (pipe_final)
  );

  // Block is complete on the edge that retires its final write.
  assign drain_done  = (state == DRAIN) & (pipe_empty | pipe_final);
  assign blk_cnt_inc = blk_cnt + BLK_CNT_W'(1);
  assign last_blk    = (blk_cnt_inc == num_blocks);

  // Bank ownership: release clears, completion sets, set wins on collision.
  assign rel_mask      = bank_release ? 2'(2'b01 << bank_release_id) : 2'b00;
  assign set_mask      = drain_done ? 2'(2'b01 << cur_bank) : 2'b00;
  assign bank_full_nxt = (bank_full & ~rel_mask) | set_mask;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && (cfg_num_blocks != '0)) state_nxt = FILL;
      FILL:      if (accept && (pix_cnt == LAST_PIX)) state_nxt = DRAIN;
      DRAIN: begin
        if (drain_done) begin
          if (last_blk)                      state_nxt = IDLE;
          else if (bank_full_nxt[~cur_bank]) state_nxt = WAIT_BANK;
          else                               state_nxt = FILL;
        end
      end
      WAIT_BANK: if (!bank_full_nxt[cur_bank]) state_nxt = FILL;
      default:   state_nxt = IDLE;
    endcase
  end

  // Counter, bank and pulse updates for the current state.
  always_comb begin
    pix_cnt_nxt    = pix_cnt;
    blk_cnt_nxt    = blk_cnt;
    num_blocks_nxt = num_blocks;
    cur_bank_nxt   = cur_bank;
    blk_done_nxt   = 1'b0;
    blk_bank_nxt   = blk_bank;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_num_blocks != '0) begin
            num_blocks_nxt = cfg_num_blocks;
            blk_cnt_nxt    = '0;
            pix_cnt_nxt    = '0;
          end else begin
            frame_done_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) pix_cnt_nxt = (pix_cnt == LAST_PIX) ? '0 : pix_cnt + AW'(1);
      end
      DRAIN: begin
        if (drain_done) begin
          blk_done_nxt   = 1'b1;
          blk_bank_nxt   = cur_bank;
          cur_bank_nxt   = ~cur_bank;
          blk_cnt_nxt    = blk_cnt_inc;
          frame_done_nxt = last_blk;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      blk_cnt    <= '0;
      num_blocks <= '0;
      cur_bank   <= 1'b0;
      bank_full  <= 2'b00;
      blk_done   <= 1'b0;
      blk_bank   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_cnt    <= pix_cnt_nxt;
      blk_cnt    <= blk_cnt_nxt;
      num_blocks <= num_blocks_nxt;
      cur_bank   <= cur_bank_nxt;
      bank_full  <= bank_full_nxt;
      blk_done   <= blk_done_nxt;
      blk_bank   <= blk_bank_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_ycbcr_block_sequencer.sv
// Bench for ycbcr_block_sequencer: one instance at converter latency 1 and
// one at latency 3, each with a behavioural converter and a write scoreboard.
module tb_ycbcr_block_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start3;
  logic [15:0] cfg;
  logic        pv, rel, rel_id;
  logic [7:0]  pr, pg, pb;

  logic        rdy1, wen1, wbank1, bd1, bb1, busy1, fd1;
  logic [7:0]  cR1, cG1, cB1;
  logic [31:0] cY1, cCb1, cCr1, wy1, wcb1, wcr1;
  logic [5:0]  wa1;
  logic        rdy3, wen3, wbank3, bd3, bb3, busy3, fd3;
  logic [7:0]  cR3, cG3, cB3;
  logic [31:0] cY3, cCb3, cCr3, wy3, wcb3, wcr3;
  logic [5:0]  wa3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [102:0] v;
    int           acyc;
  } exp_t;

  exp_t q1[$], q3[$];
  int acc1, acc3, wr1, wr3, blk1_n, blk3_n, frm1_n, frm3_n;
  int last_wr1, last_wr3, bcyc1, bcyc3, fdbd1, fdbd3;
  logic [7:0]  bseq1, bseq3;
  logic [31:0] last_y1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden RGB->YCbCr in Q16 with offset 128 on chroma.
  function automatic logic [95:0] ycc(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int ri, gi, bi, y, cb, cr;
    ri = int'(r); gi = int'(g); bi = int'(b);
    y  = 19595 * ri + 38470 * gi + 7471 * bi;
    cb = 32768 * bi - 11059 * ri - 21709 * gi + 8388608;
    cr = 32768 * ri - 27439 * gi - 5329 * bi + 8388608;
    return {32'(y), 32'(cb), 32'(cr)};
  endfunction

  // Behavioural converters.
  logic [95:0] cv1, cv3a, cv3b, cv3c;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv1 <= '0; cv3a <= '0; cv3b <= '0; cv3c <= '0;
    end else begin
      cv1  <= ycc(cR1, cG1, cB1);
      cv3a <= ycc(cR3, cG3, cB3);
      cv3b <= cv3a;
      cv3c <= cv3b;
    end
  end
  assign {cY1, cCb1, cCr1} = cv1;
  assign {cY3, cCb3, cCr3} = cv3c;

  ycbcr_block_sequencer #(.INPUT_WIDTH(8), .FIXED_POINT_LENGTH(32), .BLOCK_PIXELS(64), .CONV_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_num_blocks(cfg),
    .pix_valid(pv), .pix_ready(rdy1), .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .conv_R(cR1), .conv_G(cG1), .conv_B(cB1), .conv_Y(cY1), .conv_Cb(cCb1), .conv_Cr(cCr1),
    .wr_en(wen1), .wr_bank(wbank1), .wr_addr(wa1), .wr_y(wy1), .wr_cb(wcb1), .wr_cr(wcr1),
    .blk_done(bd1), .blk_bank(bb1), .bank_release(rel), .bank_release_id(rel_id),
    .busy(busy1), .frame_done(fd1));

  ycbcr_block_sequencer #(.INPUT_WIDTH(8), .FIXED_POINT_LENGTH(32), .BLOCK_PIXELS(64), .CONV_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cfg_num_blocks(cfg),
    .pix_valid(pv), .pix_ready(rdy3), .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .conv_R(cR3), .conv_G(cG3), .conv_B(cB3), .conv_Y(cY3), .conv_Cb(cCb3), .conv_Cr(cCr3),
    .wr_en(wen3), .wr_bank(wbank3), .wr_addr(wa3), .wr_y(wy3), .wr_cb(wcb3), .wr_cr(wcr3),
    .blk_done(bd3), .blk_bank(bb3), .bank_release(rel), .bank_release_id(rel_id),
    .busy(busy3), .frame_done(fd3));

  // Scoreboard for the latency-1 instance: push on accept, pop on write.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pv && rdy1) begin
        e.v = {6'(acc1 % 64), 1'((acc1 / 64) % 2), ycc(pr, pg, pb)};
        e.acyc = cyc;
        q1.push_back(e);
        acc1++;
      end
      if (wen1) begin
        wr1++; last_wr1 = cyc; last_y1 = wy1;
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL wr1_unexpected cyc=%0d addr=%0d", cyc, wa1);
        end else begin
          e = q1.pop_front();
          if ({wa1, wbank1, wy1, wcb1, wcr1} !== e.v || cyc - e.acyc != 1) begin
            failures++;
            $display("FAIL wr1_data cyc=%0d got=%h exp=%h latency=%0d need=1", cyc,
                     {wa1, wbank1, wy1, wcb1, wcr1}, e.v, cyc - e.acyc);
          end
        end
      end
      if (bd1) begin
        blk1_n++; bcyc1 = cyc; bseq1 = {bseq1[6:0], bb1};
        if (fd1) fdbd1++;
      end
      if (fd1) frm1_n++;
    end
  end

  // Scoreboard for the latency-3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pv && rdy3) begin
        e.v = {6'(acc3 % 64), 1'((acc3 / 64) % 2), ycc(pr, pg, pb)};
        e.acyc = cyc;
        q3.push_back(e);
        acc3++;
      end
      if (wen3) begin
        wr3++; last_wr3 = cyc;
        checks++;
        if (q3.size() == 0) begin
          failures++;
          $display("FAIL wr3_unexpected cyc=%0d addr=%0d", cyc, wa3);
        end else begin
          e = q3.pop_front();
          if ({wa3, wbank3, wy3, wcb3, wcr3} !== e.v || cyc - e.acyc != 3) begin
            failures++;
            $display("FAIL wr3_data cyc=%0d got=%h exp=%h latency=%0d need=3", cyc,
                     {wa3, wbank3, wy3, wcb3, wcr3}, e.v, cyc - e.acyc);
          end
        end
      end
      if (bd3) begin
        blk3_n++; bcyc3 = cyc; bseq3 = {bseq3[6:0], bb3};
        if (fd3) fdbd3++;
      end
      if (fd3) frm3_n++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_on();
    rst_n = 1'b0;
    q1.delete(); q3.delete();
    acc1 = 0; acc3 = 0; wr1 = 0; wr3 = 0; blk1_n = 0; blk3_n = 0; frm1_n = 0; frm3_n = 0;
    last_wr1 = 0; last_wr3 = 0; bcyc1 = 0; bcyc3 = 0; fdbd1 = 0; fdbd3 = 0;
    bseq1 = '0; bseq3 = '0; last_y1 = '0;
  endtask

  task automatic do_reset();
    reset_on();
    start1 = 0; start3 = 0; pv = 0; rel = 0; rel_id = 0; cfg = '0;
    pr = '0; pg = '0; pb = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic pulse_release(input logic id);
    rel = 1'b1; rel_id = id;
    cycle();
    rel = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy1, wen1, wa1, wbank1, bd1, bb1, busy1, fd1} !== '0) begin
      failures++;
      $display("FAIL reset_outputs1 got=%h exp=0", {rdy1, wen1, wa1, wbank1, bd1, bb1, busy1, fd1});
    end
    checks++;
    if ({rdy3, wen3, wa3, wbank3, bd3, bb3, busy3, fd3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs3 got=%h exp=0", {rdy3, wen3, wa3, wbank3, bd3, bb3, busy3, fd3});
    end
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_block();
    do_reset();
    pr = 8'd100; pg = 8'd100; pb = 8'd100; pv = 1'b1; cfg = 16'd1;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 500 && frm1_n < 1; i++) cycle();
    repeat (3) cycle();
    pv = 1'b0;
    checks++;
    if (wr1 != 64) begin failures++; $display("FAIL single_writes got=%0d exp=64", wr1); end
    checks++;
    if (bcyc1 != last_wr1 + 1 || fdbd1 != 1) begin
      failures++;
      $display("FAIL single_blk_done blk_cyc=%0d exp=%0d with_frame=%0d exp=1", bcyc1, last_wr1 + 1, fdbd1);
    end
    checks++;
    if (blk1_n != 1 || bseq1[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_bank blocks=%0d bank=%0b exp 1 block in bank 0", blk1_n, bseq1[0]);
    end
    checks++;
    if (last_y1 !== 32'd6553600) begin failures++; $display("FAIL single_y got=%0d exp=6553600", last_y1); end
    checks++;
    if (busy1 !== 1'b0 || rdy1 !== 1'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b ready=%b exp 0 0", busy1, rdy1);
    end
  endtask

  task automatic test_three_blocks();
    do_reset();
    pv = 1'b1; cfg = 16'd3;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 1000 && blk1_n < 2; i++) begin
      pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom); cycle();
    end
    repeat (10) cycle();
    checks++;
    if (rdy1 !== 1'b0 || busy1 !== 1'b1 || acc1 != 128) begin
      failures++;
      $display("FAIL three_wait ready=%b busy=%b accepted=%0d exp 0 1 128", rdy1, busy1, acc1);
    end
    pulse_release(1'b0);
    checks++;
    if (rdy1 !== 1'b1) begin failures++; $display("FAIL three_resume ready=%b exp=1", rdy1); end
    for (int i = 0; i < 1000 && frm1_n < 1; i++) begin
      pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom); cycle();
    end
    pv = 1'b0;
    repeat (3) cycle();
    checks++;
    if (blk1_n != 3 || bseq1[2:0] !== 3'b010 || fdbd1 != 1 || frm1_n != 1) begin
      failures++;
      $display("FAIL three_seq blocks=%0d banks=%b frame_with_blk=%0d frames=%0d exp 3 010 1 1",
               blk1_n, bseq1[2:0], fdbd1, frm1_n);
    end
    checks++;
    if (wr1 != 192 || q1.size() != 0) begin
      failures++;
      $display("FAIL three_writes got=%0d pending=%0d exp 192 0", wr1, q1.size());
    end
  endtask

  task automatic test_release_collision();
    do_reset();
    pv = 1'b1; cfg = 16'd4; pr = 8'd10; pg = 8'd200; pb = 8'd77;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 1000 && !(wen1 && wa1 == 6'd63 && wbank1); i++) cycle();
    pulse_release(1'b1);
    checks++;
    if (bd1 !== 1'b1 || bb1 !== 1'b1) begin
      failures++;
      $display("FAIL collide_align blk_done=%b blk_bank=%b exp 1 1", bd1, bb1);
    end
    repeat (10) cycle();
    checks++;
    if (rdy1 !== 1'b0 || acc1 != 128) begin
      failures++;
      $display("FAIL collide_wait1 ready=%b accepted=%0d exp 0 128", rdy1, acc1);
    end
    pulse_release(1'b0);
    for (int i = 0; i < 1000 && blk1_n < 3; i++) cycle();
    repeat (10) cycle();
    checks++;
    if (rdy1 !== 1'b0 || busy1 !== 1'b1 || acc1 != 192) begin
      failures++;
      $display("FAIL collide_set_wins ready=%b busy=%b accepted=%0d exp 0 1 192", rdy1, busy1, acc1);
    end
    pulse_release(1'b1);
    for (int i = 0; i < 1000 && frm1_n < 1; i++) cycle();
    pv = 1'b0;
    repeat (3) cycle();
    checks++;
    if (blk1_n != 4 || bseq1[3:0] !== 4'b0101 || fdbd1 != 1) begin
      failures++;
      $display("FAIL collide_seq blocks=%0d banks=%b frame_with_blk=%0d exp 4 0101 1", blk1_n, bseq1[3:0], fdbd1);
    end
  endtask

  task automatic test_random_lat3();
    do_reset();
    cfg = 16'd2;
    start3 = 1'b1; cycle(); start3 = 1'b0;
    for (int i = 0; i < 3000 && frm3_n < 1; i++) begin
      pv = 1'($urandom_range(0, 1));
      pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
      cycle();
    end
    pv = 1'b0;
    repeat (5) cycle();
    checks++;
    if (wr3 != 128 || q3.size() != 0) begin
      failures++;
      $display("FAIL lat3_writes got=%0d pending=%0d exp 128 0", wr3, q3.size());
    end
    checks++;
    if (blk3_n != 2 || bseq3[1:0] !== 2'b01 || fdbd3 != 1) begin
      failures++;
      $display("FAIL lat3_blocks blocks=%0d banks=%b frame_with_blk=%0d exp 2 01 1", blk3_n, bseq3[1:0], fdbd3);
    end
    checks++;
    if (bcyc3 != last_wr3 + 1 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL lat3_done blk_cyc=%0d exp=%0d busy=%b", bcyc3, last_wr3 + 1, busy3);
    end
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    pv = 1'b1; cfg = 16'd1; pr = 8'd33; pg = 8'd66; pb = 8'd99;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 200 && acc1 < 30; i++) cycle();
    reset_on();
    #1;
    checks++;
    if ({rdy1, wen1, wa1, wbank1, bd1, bb1, busy1, fd1} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0", {rdy1, wen1, wa1, wbank1, bd1, bb1, busy1, fd1});
    end
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (10) cycle();
    checks++;
    if (wr1 != 0 || blk1_n != 0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet writes=%0d blk_done=%0d busy=%b exp 0 0 0", wr1, blk1_n, busy1);
    end
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 500 && frm1_n < 1; i++) cycle();
    pv = 1'b0;
    repeat (3) cycle();
    checks++;
    if (wr1 != 64 || blk1_n != 1 || bseq1[0] !== 1'b0) begin
      failures++;
      $display("FAIL midreset_replay writes=%0d blocks=%0d bank=%b exp 64 1 0", wr1, blk1_n, bseq1[0]);
    end
  endtask

  task automatic test_start_rules();
    do_reset();
    cfg = 16'd0;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    checks++;
    if (fd1 !== 1'b1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_frame_done frame_done=%b busy=%b exp 1 0", fd1, busy1);
    end
    cycle();
    checks++;
    if (fd1 !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL zero_after frame_done=%b busy=%b exp 0 0", fd1, busy1);
    end
    do_reset();
    pv = 1'b1; cfg = 16'd2; pr = 8'd5; pg = 8'd6; pb = 8'd7;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    repeat (20) cycle();
    cfg = 16'd5;
    start1 = 1'b1; cycle(); start1 = 1'b0;
    for (int i = 0; i < 1000 && frm1_n < 1; i++) cycle();
    pv = 1'b0;
    repeat (20) cycle();
    checks++;
    if (blk1_n != 2 || wr1 != 128 || fdbd1 != 1 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL busy_start blocks=%0d writes=%0d frame_with_blk=%0d busy=%b exp 2 128 1 0",
               blk1_n, wr1, fdbd1, busy1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_block();
    test_three_blocks();
    test_release_collision();
    test_random_lat3();
    test_reset_mid_block();
    test_start_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
